phys_reg_map_table: RTL and testbench
=====================================

PHYS_REG_MAP_TABLE -- requirements
Module: phys_reg_map_table

Interface
REQ-001 SHALL have ports: CLK  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: rename_valid  in  1  rename one instruction this cycle.
REQ-004 SHALL have: rename_dest_arch_reg_tag  in  5; rename_source_0_arch_reg_tag, rename_source_1_arch_reg_tag  in  5 each.
REQ-005 SHALL have: rename_new_dest_phys_reg_tag  in  6  tag from the free list dequeue port.
REQ-006 SHALL have: source_0_phys_reg_tag, source_1_phys_reg_tag  out  6  current source mappings.
REQ-007 SHALL have: old_dest_phys_reg_tag  out  6  current mapping of the dest, forwarded to the ROB.
REQ-008 SHALL have: free_list_dequeue_valid  out  1  request to pop one free tag.
REQ-009 SHALL have: revert_valid  in  1; revert_dest_arch_reg_tag  in  5; revert_safe_dest_phys_reg_tag  in  6.
REQ-010 SHALL have: save_checkpoint_valid  in  1; save_checkpoint_ROB_index  in  4; save_checkpoint_column  out  2; save_checkpoint_success  out  1.
REQ-011 SHALL have: restore_checkpoint_valid  in  1; restore_checkpoint_speculate_failed  in  1; restore_checkpoint_ROB_index  in  4; restore_checkpoint_column  in  2; restore_checkpoint_success  out  1.

Function
REQ-012 SHALL hold a 32-entry map, arch reg -> 6-bit phys reg tag.
REQ-013 SHALL hold 4 checkpoint columns, each with a valid bit, a 4-bit ROB index tag and a full 32-entry map copy.
REQ-014 SHALL hold a 2-bit checkpoint head pointer that wraps from 3 to 0.
REQ-015 SHALL drive source and old-dest outputs combinationally from the map as it stands before this cycle's write, with no same-cycle bypass.
REQ-016 SHALL read arch reg 0 as phys 0; renames to arch 0 SHALL NOT write the map.
REQ-017 SHALL drive free_list_dequeue_valid = rename_valid & (dest != 0) & ~restore_checkpoint_valid & ~revert_valid.
REQ-018 SHALL, on an accepted rename (the dequeue condition of REQ-017), write map[dest] <= rename_new_dest_phys_reg_tag at the next edge.
REQ-019 SHALL, on revert_valid without restore_checkpoint_valid, write map[revert_dest] <= revert_safe_dest_phys_reg_tag; revert_dest 0 SHALL be ignored.
REQ-020 SHALL drive save_checkpoint_column = head and save_checkpoint_success = save_checkpoint_valid & ~valid[head], both combinational.
REQ-021 SHALL, on a successful save: set valid[head], store the ROB index tag, and advance head by 1.
REQ-022 SHALL store in the saved copy the map including any same-cycle accepted rename write.
REQ-023 SHALL, on a failed save (column full), make no checkpoint change.
REQ-024 SHALL drive restore_checkpoint_success = restore_checkpoint_valid & valid[col] & (tag[col] == restore_checkpoint_ROB_index), combinational.
REQ-025 SHALL, on a successful restore with speculate_failed=1: load the map from the column copy, clear all four valid bits, and set head = col.
REQ-026 SHALL, on a successful restore with speculate_failed=0: clear only valid[col], with no map change.
REQ-027 SHALL, on a failed restore: make no state change, and SHALL still block rename and revert that cycle.
REQ-028 SHALL apply this priority when events coincide: restore, then revert, then rename; a save and a restore in the same cycle SHALL be served restore-first.

Reset
REQ-029 SHALL, while nRST=0, set map[i] = i for i = 0..31, clear all checkpoint valid bits and tags, and set head = 0.
REQ-030 SHALL, in reset, drive free_list_dequeue_valid=0, save_checkpoint_success=0 and restore_checkpoint_success=0.
REQ-031 SHALL, if reset is asserted mid-operation, discard pending writes immediately, independent of CLK.

Verification
REQ-032 SHALL cover: reset, then read sources r3/r7 -> 0x03/0x07, old_dest matches, all success outputs 0.
REQ-033 SHALL cover: rename r5 <- 0x20 with dequeue_valid=1; next cycle read r5 -> 0x20; rename to r0 -> dequeue_valid=0 and r0 reads 0.
REQ-034 SHALL cover: 4 saves with ROB 1..4 -> columns 0..3, success=1; 5th save -> success=0 and column=0.
REQ-035 SHALL cover: save at ROB 2 (col 0), rename r5 <- 0x21, restore col 0 / ROB 2 / failed=1 -> success=1, r5 reads pre-rename value, head=0.
REQ-036 SHALL cover: restore with a mismatched ROB index -> success=0, map unchanged, same-cycle rename blocked (dequeue_valid=0).
REQ-037 SHALL cover: revert r9 -> 0x09 together with a rename of r9 -> revert wins, dequeue_valid=0, r9 reads 0x09.

Source files
------------

// File: rtl/phys_reg_map_table.sv
// Register rename map table: arch -> phys tag mapping with four branch checkpoints.
// Restore has priority over revert, and revert has priority over rename; a flush also squashes any save in the same cycle.
module phys_reg_map_table (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       rename_valid,
  input  logic [4:0] rename_dest_arch_reg_tag,
  input  logic [4:0] rename_source_0_arch_reg_tag,
  input  logic [4:0] rename_source_1_arch_reg_tag,
  input  logic [5:0] rename_new_dest_phys_reg_tag,
  output logic [5:0] source_0_phys_reg_tag,
  output logic [5:0] source_1_phys_reg_tag,
  output logic [5:0] old_dest_phys_reg_tag,
  output logic       free_list_dequeue_valid,
  input  logic       revert_valid,
  input  logic [4:0] revert_dest_arch_reg_tag,
  input  logic [5:0] revert_safe_dest_phys_reg_tag,
  input  logic       save_checkpoint_valid,
  input  logic [3:0] save_checkpoint_ROB_index,
  output logic [1:0] save_checkpoint_column,
  output logic       save_checkpoint_success,
  input  logic       restore_checkpoint_valid,
  input  logic       restore_checkpoint_speculate_failed,
  input  logic [3:0] restore_checkpoint_ROB_index,
  input  logic [1:0] restore_checkpoint_column,
  output logic       restore_checkpoint_success
);

  logic [5:0] r_map [32];
  logic [5:0] r_ckptMap [4][32];
  logic [3:0] r_ckptTag [4];
  logic [3:0] r_ckptValid;
  logic [1:0] r_head;

  logic [5:0] w_mapNext [32];
  logic       w_renameWrite;
  logic       w_revertWrite;
  logic       w_restoreFlush;
  logic       w_restoreRelease;

  // Reads see the map before this cycle's write; arch reg 0 is hardwired to phys 0.
  assign source_0_phys_reg_tag = (rename_source_0_arch_reg_tag == 5'd0) ? 6'd0 : r_map[rename_source_0_arch_reg_tag];
  assign source_1_phys_reg_tag = (rename_source_1_arch_reg_tag == 5'd0) ? 6'd0 : r_map[rename_source_1_arch_reg_tag];
  assign old_dest_phys_reg_tag = (rename_dest_arch_reg_tag == 5'd0) ? 6'd0 : r_map[rename_dest_arch_reg_tag];

  assign free_list_dequeue_valid = nRST & rename_valid & (rename_dest_arch_reg_tag != 5'd0)
                                 & ~restore_checkpoint_valid & ~revert_valid;
  assign w_renameWrite = free_list_dequeue_valid;
  assign w_revertWrite = nRST & revert_valid & ~restore_checkpoint_valid & (revert_dest_arch_reg_tag != 5'd0);

  assign save_checkpoint_column  = r_head;
  assign save_checkpoint_success = nRST & save_checkpoint_valid & ~r_ckptValid[r_head];

  assign restore_checkpoint_success = nRST & restore_checkpoint_valid
                                    & r_ckptValid[restore_checkpoint_column]
                                    & (r_ckptTag[restore_checkpoint_column] == restore_checkpoint_ROB_index);
  assign w_restoreFlush   = restore_checkpoint_success & restore_checkpoint_speculate_failed;
  assign w_restoreRelease = restore_checkpoint_success & ~restore_checkpoint_speculate_failed;

  always_comb begin
    w_mapNext = r_map;
    if (w_revertWrite)
      w_mapNext[revert_dest_arch_reg_tag] = revert_safe_dest_phys_reg_tag;
    else if (w_renameWrite)
      w_mapNext[rename_dest_arch_reg_tag] = rename_new_dest_phys_reg_tag;
  end

  // A saved copy captures w_mapNext so a rename accepted alongside the save is part of it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 32; i++) begin
        r_map[i] <= 6'(i);
        for (int c = 0; c < 4; c++) r_ckptMap[c][i] <= 6'(i);
      end
      for (int c = 0; c < 4; c++) r_ckptTag[c] <= 4'd0;
      r_ckptValid <= 4'd0;
      r_head      <= 2'd0;
    end else if (w_restoreFlush) begin
      r_map       <= r_ckptMap[restore_checkpoint_column];
      r_ckptValid <= 4'd0;
      r_head      <= restore_checkpoint_column;
    end else begin
      r_map <= w_mapNext;
      if (save_checkpoint_success) begin
        r_ckptValid[r_head] <= 1'b1;
        r_ckptTag[r_head]   <= save_checkpoint_ROB_index;
        r_ckptMap[r_head]   <= w_mapNext;
        r_head              <= r_head + 2'd1;
      end
      if (w_restoreRelease)
        r_ckptValid[restore_checkpoint_column] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phys_reg_map_table.sv
// Directed testbench for phys_reg_map_table: hand-computed expectations checked with immediate assertions.
module tb_phys_reg_map_table;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       rename_valid;
  logic [4:0] rename_dest_arch_reg_tag;
  logic [4:0] rename_source_0_arch_reg_tag;
  logic [4:0] rename_source_1_arch_reg_tag;
  logic [5:0] rename_new_dest_phys_reg_tag;
  logic [5:0] source_0_phys_reg_tag;
  logic [5:0] source_1_phys_reg_tag;
  logic [5:0] old_dest_phys_reg_tag;
  logic       free_list_dequeue_valid;
  logic       revert_valid;
  logic [4:0] revert_dest_arch_reg_tag;
  logic [5:0] revert_safe_dest_phys_reg_tag;
  logic       save_checkpoint_valid;
  logic [3:0] save_checkpoint_ROB_index;
  logic [1:0] save_checkpoint_column;
  logic       save_checkpoint_success;
  logic       restore_checkpoint_valid;
  logic       restore_checkpoint_speculate_failed;
  logic [3:0] restore_checkpoint_ROB_index;
  logic [1:0] restore_checkpoint_column;
  logic       restore_checkpoint_success;

  int totalCount = 0;
  int badCount   = 0;

  phys_reg_map_table dut (
    .CLK                                 (CLK),
    .nRST                                (nRST),
    .rename_valid                        (rename_valid),
    .rename_dest_arch_reg_tag            (rename_dest_arch_reg_tag),
    .rename_source_0_arch_reg_tag        (rename_source_0_arch_reg_tag),
    .rename_source_1_arch_reg_tag        (rename_source_1_arch_reg_tag),
    .rename_new_dest_phys_reg_tag        (rename_new_dest_phys_reg_tag),
    .source_0_phys_reg_tag               (source_0_phys_reg_tag),
    .source_1_phys_reg_tag               (source_1_phys_reg_tag),
    .old_dest_phys_reg_tag               (old_dest_phys_reg_tag),
    .free_list_dequeue_valid             (free_list_dequeue_valid),
    .revert_valid                        (revert_valid),
    .revert_dest_arch_reg_tag            (revert_dest_arch_reg_tag),
    .revert_safe_dest_phys_reg_tag       (revert_safe_dest_phys_reg_tag),
    .save_checkpoint_valid               (save_checkpoint_valid),
    .save_checkpoint_ROB_index           (save_checkpoint_ROB_index),
    .save_checkpoint_column              (save_checkpoint_column),
    .save_checkpoint_success             (save_checkpoint_success),
    .restore_checkpoint_valid            (restore_checkpoint_valid),
    .restore_checkpoint_speculate_failed (restore_checkpoint_speculate_failed),
    .restore_checkpoint_ROB_index        (restore_checkpoint_ROB_index),
    .restore_checkpoint_column           (restore_checkpoint_column),
    .restore_checkpoint_success          (restore_checkpoint_success)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    totalCount++;
    assert (observed === expected)
    else begin
      badCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change one time unit after the rising edge, so checks land mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus();
    #1;
  endtask

  task automatic idle();
    rename_valid                        = 1'b0;
    rename_dest_arch_reg_tag            = 5'd0;
    rename_source_0_arch_reg_tag        = 5'd0;
    rename_source_1_arch_reg_tag        = 5'd0;
    rename_new_dest_phys_reg_tag        = 6'd0;
    revert_valid                        = 1'b0;
    revert_dest_arch_reg_tag            = 5'd0;
    revert_safe_dest_phys_reg_tag       = 6'd0;
    save_checkpoint_valid               = 1'b0;
    save_checkpoint_ROB_index           = 4'd0;
    restore_checkpoint_valid            = 1'b0;
    restore_checkpoint_speculate_failed = 1'b0;
    restore_checkpoint_ROB_index        = 4'd0;
    restore_checkpoint_column           = 2'd0;
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    // Outputs held low while in reset even with requests present
    rename_valid = 1'b1; rename_dest_arch_reg_tag = 5'd5;
    save_checkpoint_valid = 1'b1;
    applyStimulus();
    checkOutput("rst_dequeue", 8'(free_list_dequeue_valid), 8'h0);
    checkOutput("rst_save_ok", 8'(save_checkpoint_success), 8'h0);
    idle();
    #20 nRST = 1'b1;
    tick();

    // Reset map contents
    rename_source_0_arch_reg_tag = 5'd3; rename_source_1_arch_reg_tag = 5'd7; rename_dest_arch_reg_tag = 5'd3;
    applyStimulus();
    checkOutput("reset_src0_r3", 8'(source_0_phys_reg_tag), 8'h03);
    checkOutput("reset_src1_r7", 8'(source_1_phys_reg_tag), 8'h07);
    checkOutput("reset_olddest_r3", 8'(old_dest_phys_reg_tag), 8'h03);
    checkOutput("reset_save_ok", 8'(save_checkpoint_success), 8'h0);
    checkOutput("reset_restore_ok", 8'(restore_checkpoint_success), 8'h0);
    checkOutput("reset_save_col", 8'(save_checkpoint_column), 8'h0);
    tick();

    // Rename r5 <- 0x20, no same-cycle bypass
    idle();
    rename_valid = 1'b1; rename_dest_arch_reg_tag = 5'd5; rename_new_dest_phys_reg_tag = 6'h20;
    rename_source_0_arch_reg_tag = 5'd5;
    applyStimulus();
    checkOutput("rename_dequeue", 8'(free_list_dequeue_valid), 8'h1);
    checkOutput("rename_olddest", 8'(old_dest_phys_reg_tag), 8'h05);
    checkOutput("rename_nobypass", 8'(source_0_phys_reg_tag), 8'h05);
    tick();
    idle();
    rename_source_0_arch_reg_tag = 5'd5;
    applyStimulus();
    checkOutput("rename_r5_after", 8'(source_0_phys_reg_tag), 8'h20);

    // Rename to r0 is not accepted
    rename_valid = 1'b1; rename_dest_arch_reg_tag = 5'd0; rename_new_dest_phys_reg_tag = 6'h2A;
    rename_source_0_arch_reg_tag = 5'd0;
    applyStimulus();
    checkOutput("rename_r0_dequeue", 8'(free_list_dequeue_valid), 8'h0);
    tick();
    idle();
    applyStimulus();
    checkOutput("rename_r0_read", 8'(source_0_phys_reg_tag), 8'h00);

    // Four saves fill columns 0..3, fifth fails at column 0
    for (int i = 1; i <= 4; i++) begin
      idle();
      save_checkpoint_valid = 1'b1; save_checkpoint_ROB_index = 4'(i);
      applyStimulus();
      checkOutput("save_col", 8'(save_checkpoint_column), 8'(i - 1));
      checkOutput("save_ok", 8'(save_checkpoint_success), 8'h1);
      tick();
    end
    idle();
    save_checkpoint_valid = 1'b1; save_checkpoint_ROB_index = 4'd5;
    applyStimulus();
    checkOutput("save_full_ok", 8'(save_checkpoint_success), 8'h0);
    checkOutput("save_full_col", 8'(save_checkpoint_column), 8'h0);
    tick();

    // Mismatched ROB index fails and blocks a same-cycle rename
    idle();
    restore_checkpoint_valid = 1'b1; restore_checkpoint_speculate_failed = 1'b1;
    restore_checkpoint_column = 2'd1; restore_checkpoint_ROB_index = 4'd7;
    rename_valid = 1'b1; rename_dest_arch_reg_tag = 5'd5; rename_new_dest_phys_reg_tag = 6'h30;
    applyStimulus();
    checkOutput("bad_restore_ok", 8'(restore_checkpoint_success), 8'h0);
    checkOutput("bad_restore_dequeue", 8'(free_list_dequeue_valid), 8'h0);
    tick();
    idle();
    rename_source_0_arch_reg_tag = 5'd5;
    save_checkpoint_valid = 1'b1;
    applyStimulus();
    checkOutput("bad_restore_map", 8'(source_0_phys_reg_tag), 8'h20);
    checkOutput("bad_restore_still_full", 8'(save_checkpoint_success), 8'h0);

    // Good restore of column 0 (ROB 1) flushes all checkpoints
    idle();
    restore_checkpoint_valid = 1'b1; restore_checkpoint_speculate_failed = 1'b1;
    restore_checkpoint_column = 2'd0; restore_checkpoint_ROB_index = 4'd1;
    applyStimulus();
    checkOutput("flush_restore_ok", 8'(restore_checkpoint_success), 8'h1);
    tick();

    // Save at ROB 2 into column 0, rename r5 <- 0x21, then roll back
    idle();
    save_checkpoint_valid = 1'b1; save_checkpoint_ROB_index = 4'd2;
    applyStimulus();
    checkOutput("ck2_save_ok", 8'(save_checkpoint_success), 8'h1);
    checkOutput("ck2_save_col", 8'(save_checkpoint_column), 8'h0);
    tick();
    idle();
    rename_valid = 1'b1; rename_dest_arch_reg_tag = 5'd5; rename_new_dest_phys_reg_tag = 6'h21;
    tick();
    idle();
    rename_source_0_arch_reg_tag = 5'd5;
    applyStimulus();
    checkOutput("ck2_r5_renamed", 8'(source_0_phys_reg_tag), 8'h21);
    restore_checkpoint_valid = 1'b1; restore_checkpoint_speculate_failed = 1'b1;
    restore_checkpoint_column = 2'd0; restore_checkpoint_ROB_index = 4'd2;
    applyStimulus();
    checkOutput("ck2_restore_ok", 8'(restore_checkpoint_success), 8'h1);
    tick();
    idle();
    rename_source_0_arch_reg_tag = 5'd5;
    save_checkpoint_valid = 1'b1; save_checkpoint_ROB_index = 4'd3;
    rename_valid = 1'b1; rename_dest_arch_reg_tag = 5'd6; rename_new_dest_phys_reg_tag = 6'h22;
    applyStimulus();
    checkOutput("ck2_r5_restored", 8'(source_0_phys_reg_tag), 8'h20);
    checkOutput("ck2_head", 8'(save_checkpoint_column), 8'h0);
    checkOutput("ck3_save_ok", 8'(save_checkpoint_success), 8'h1);
    tick();

    // Saved copy includes the rename r6 <- 0x22 accepted with the save
    idle();
    rename_valid = 1'b1; rename_dest_arch_reg_tag = 5'd6; rename_new_dest_phys_reg_tag = 6'h23;
    tick();
    idle();
    restore_checkpoint_valid = 1'b1; restore_checkpoint_speculate_failed = 1'b1;
    restore_checkpoint_column = 2'd0; restore_checkpoint_ROB_index = 4'd3;
    rename_source_0_arch_reg_tag = 5'd6;
    applyStimulus();
    checkOutput("ck3_r6_before", 8'(source_0_phys_reg_tag), 8'h23);
    checkOutput("ck3_restore_ok", 8'(restore_checkpoint_success), 8'h1);
    tick();
    idle();
    rename_source_0_arch_reg_tag = 5'd6;
    applyStimulus();
    checkOutput("ck3_r6_restored", 8'(source_0_phys_reg_tag), 8'h22);

    // Non-speculative restore only frees its column
    save_checkpoint_valid = 1'b1; save_checkpoint_ROB_index = 4'd5;
    tick();
    idle();
    rename_valid = 1'b1; rename_dest_arch_reg_tag = 5'd7; rename_new_dest_phys_reg_tag = 6'h24;
    tick();
    idle();
    restore_checkpoint_valid = 1'b1; restore_checkpoint_speculate_failed = 1'b0;
    restore_checkpoint_column = 2'd0; restore_checkpoint_ROB_index = 4'd5;
    applyStimulus();
    checkOutput("commit_restore_ok", 8'(restore_checkpoint_success), 8'h1);
    tick();
    idle();
    rename_source_0_arch_reg_tag = 5'd7;
    applyStimulus();
    checkOutput("commit_r7_kept", 8'(source_0_phys_reg_tag), 8'h24);
    checkOutput("commit_head", 8'(save_checkpoint_column), 8'h1);
    restore_checkpoint_valid = 1'b1; restore_checkpoint_speculate_failed = 1'b0;
    restore_checkpoint_column = 2'd0; restore_checkpoint_ROB_index = 4'd5;
    applyStimulus();
    checkOutput("commit_col0_freed", 8'(restore_checkpoint_success), 8'h0);
    tick();

    // Revert beats a same-cycle rename of the same register
    idle();
    rename_valid = 1'b1; rename_dest_arch_reg_tag = 5'd9; rename_new_dest_phys_reg_tag = 6'h26;
    tick();
    idle();
    revert_valid = 1'b1; revert_dest_arch_reg_tag = 5'd9; revert_safe_dest_phys_reg_tag = 6'h09;
    rename_valid = 1'b1; rename_dest_arch_reg_tag = 5'd9; rename_new_dest_phys_reg_tag = 6'h25;
    applyStimulus();
    checkOutput("revert_dequeue", 8'(free_list_dequeue_valid), 8'h0);
    checkOutput("revert_olddest", 8'(old_dest_phys_reg_tag), 8'h26);
    tick();
    idle();
    rename_source_1_arch_reg_tag = 5'd9;
    applyStimulus();
    checkOutput("revert_r9", 8'(source_1_phys_reg_tag), 8'h09);

    // Asynchronous reset mid-cycle discards the pending rename
    rename_valid = 1'b1; rename_dest_arch_reg_tag = 5'd9; rename_new_dest_phys_reg_tag = 6'h3F;
    #2 nRST = 1'b0;
    #1;
    checkOutput("async_rst_r9", 8'(source_1_phys_reg_tag), 8'h09);
    checkOutput("async_rst_dequeue", 8'(free_list_dequeue_valid), 8'h0);
    rename_source_0_arch_reg_tag = 5'd7;
    applyStimulus();
    checkOutput("async_rst_r7", 8'(source_0_phys_reg_tag), 8'h07);
    idle();
    tick();
    nRST = 1'b1;
    rename_source_0_arch_reg_tag = 5'd5;
    applyStimulus();
    checkOutput("post_rst_r5", 8'(source_0_phys_reg_tag), 8'h05);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
